// File: rtl/angle_range_reducer_pkg.sv
// Shared constants and FSM state type for the angle range reducer and its fold stage.
package angle_range_reducer_pkg;

  localparam int INPUTOUTBIT = 16;
  localparam int DEG_90      = 90;
  localparam int DEG_180     = 180;
  localparam int DEG_360     = 360;
  localparam int DEG_MAX_ABS = 999;

  // Enough cycles to absorb the worst case of three +/-360 steps plus the exit check.
  localparam int WRAP_FIXED_CYCLES = 4;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WRAP,
    FOLD,
    DONE_ST
  } state_t;

endpackage

// File: rtl/angle_range_reducer_if.sv
// Start/result handshake between the reducer and its client (e.g. deg_to_rad).
interface angle_range_reducer_if #(
  parameter int DATA_W = angle_range_reducer_pkg::INPUTOUTBIT
);
  logic                     start;
  logic signed [DATA_W-1:0] angle_deg;
  logic signed [DATA_W-1:0] reduced_deg;
  logic                     sin_neg;
  logic                     cos_neg;
  logic                     out_valid;
  logic                     error;
  logic                     busy;
  logic                     done;

  modport master (
    output start, angle_deg,
    input  reduced_deg, sin_neg, cos_neg, out_valid, error, busy, done
  );

  modport slave (
    input  start, angle_deg,
    output reduced_deg, sin_neg, cos_neg, out_valid, error, busy, done
  );
endinterface

// File: rtl/angle_range_reducer_quadrant_fold.sv
// Combinational fold of an angle in [0, 359] degrees onto [-90, 90] with sin/cos sign flags.
module angle_range_reducer_quadrant_fold
  import angle_range_reducer_pkg::*;
#(
  parameter int W = INPUTOUTBIT + 1
) (
  input  logic signed [W-1:0] angle,
  output logic signed [W-1:0] reduced,
  output logic                sin_neg,
  output logic                cos_neg
);

  localparam logic signed [W-1:0] C90  = W'(DEG_90);
  localparam logic signed [W-1:0] C180 = W'(DEG_180);
  localparam logic signed [W-1:0] C270 = W'(DEG_180 + DEG_90);
  localparam logic signed [W-1:0] C360 = W'(DEG_360);

  always_comb begin
    reduced = angle;
    sin_neg = 1'b0;
    cos_neg = 1'b0;
    if (angle <= C90) begin
      reduced = angle;
    end else if (angle <= C180) begin
      reduced = C180 - angle;
      cos_neg = 1'b1;
    end else if (angle <= C270) begin
      reduced = angle - C180;
      sin_neg = 1'b1;
      cos_neg = 1'b1;
    end else begin
      reduced = angle - C360;
    end
  end

endmodule

// File: rtl/angle_range_reducer.sv
// Reduces integer degrees in [-999, 999] to [-90, 90] plus sin/cos sign flags.
// Define ANGLE_REDUCE_FIXED_LAT_EN to pad WRAP to a fixed four cycles.
module angle_range_reducer
  import angle_range_reducer_pkg::*;
#(
  parameter int DATA_W      = INPUTOUTBIT,
  parameter int MAX_ABS_DEG = DEG_MAX_ABS
) (
  input logic                  clk,
  input logic                  rst,
  angle_range_reducer_if.slave bus
);

  localparam int ACC_W = DATA_W + 1;
  localparam logic signed [ACC_W-1:0] C360    = ACC_W'(DEG_360);
  localparam logic signed [ACC_W-1:0] MAX_POS = ACC_W'(MAX_ABS_DEG);
  localparam logic signed [ACC_W-1:0] MAX_NEG = -MAX_POS;

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] fold_reduced;
  logic                    fold_sin_neg;
  logic                    fold_cos_neg;
  logic                    acc_high;
  logic                    acc_low;

`ifdef ANGLE_REDUCE_FIXED_LAT_EN
  logic [1:0] wrap_cnt;
`endif

  angle_range_reducer_quadrant_fold #(.W(ACC_W)) u_fold (
    .angle   (acc),
    .reduced (fold_reduced),
    .sin_neg (fold_sin_neg),
    .cos_neg (fold_cos_neg)
  );

  assign acc_high = (acc >= C360);
  assign acc_low  = (acc < 0);
  assign bus.busy = (state != IDLE);

  // Single FSM owning the accumulator and every registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      acc             <= '0;
      bus.reduced_deg <= '0;
      bus.sin_neg     <= 1'b0;
      bus.cos_neg     <= 1'b0;
      bus.out_valid   <= 1'b0;
      bus.error       <= 1'b0;
      bus.done        <= 1'b0;
`ifdef ANGLE_REDUCE_FIXED_LAT_EN
      wrap_cnt        <= '0;
`endif
    end else begin
      bus.out_valid <= 1'b0;
      bus.done      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc       <= {bus.angle_deg[DATA_W-1], bus.angle_deg};
            bus.error <= 1'b0;
            state     <= CHECK;
`ifdef ANGLE_REDUCE_FIXED_LAT_EN
            wrap_cnt  <= '0;
`endif
          end
        end
        CHECK: begin
          if (acc > MAX_POS || acc < MAX_NEG) begin
            bus.error <= 1'b1;
            state     <= DONE_ST;
          end else begin
            state <= WRAP;
          end
        end
        WRAP: begin
`ifdef ANGLE_REDUCE_FIXED_LAT_EN
          // Steps stop once in range; the counter alone decides when to leave.
          if (acc_high) begin
            acc <= acc - C360;
          end else if (acc_low) begin
            acc <= acc + C360;
          end
          if (wrap_cnt == 2'(WRAP_FIXED_CYCLES - 1)) begin
            state <= FOLD;
          end else begin
            wrap_cnt <= wrap_cnt + 2'd1;
          end
`else
          if (acc_high) begin
            acc <= acc - C360;
          end else if (acc_low) begin
            acc <= acc + C360;
          end else begin
            state <= FOLD;
          end
`endif
        end
        FOLD: begin
          bus.reduced_deg <= fold_reduced[DATA_W-1:0];
          bus.sin_neg     <= fold_sin_neg;
          bus.cos_neg     <= fold_cos_neg;
          bus.out_valid   <= 1'b1;
          state           <= DONE_ST;
        end
        DONE_ST: begin
          bus.done <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_angle_range_reducer.sv
// Randomized and directed checks of angle_range_reducer against a modulo-arithmetic reference model.
module tb_angle_range_reducer;

  localparam int DATA_W = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   prev_red;
  bit   prev_sin;
  bit   prev_cos;

  angle_range_reducer_if #(.DATA_W(DATA_W)) bus ();

  angle_range_reducer #(.DATA_W(DATA_W), .MAX_ABS_DEG(999)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference: reduce with a true modulo, then pick the quadrant.
  function automatic void model(input int a, output int red, output bit sn, output bit cn,
                                output int k, output bit err);
    int m;
    err = (a > 999) || (a < -999);
    k   = (a >= 0) ? (a / 360) : ((-a + 359) / 360);
    m   = ((a % 360) + 360) % 360;
    sn  = 1'b0;
    cn  = 1'b0;
    if (m <= 90) red = m;
    else if (m <= 180) begin red = 180 - m; cn = 1'b1; end
    else if (m <= 270) begin red = m - 180; sn = 1'b1; cn = 1'b1; end
    else red = m - 360;
  endfunction

  task automatic applyStimulus(input int a, input bit repulse, input int other);
    int n, ov_at, done_at, exp_red, exp_k, exp_ov, exp_done;
    bit exp_sn, exp_cn, exp_err;
    model(a, exp_red, exp_sn, exp_cn, exp_k, exp_err);
`ifdef ANGLE_REDUCE_FIXED_LAT_EN
    exp_ov = exp_err ? -1 : 6;
`else
    exp_ov = exp_err ? -1 : 3 + exp_k;
`endif
    exp_done = exp_err ? 2 : exp_ov + 1;
    if (exp_err) begin
      exp_red = prev_red;
      exp_sn  = prev_sin;
      exp_cn  = prev_cos;
    end
    @(negedge clk);
    bus.start     = 1'b1;
    bus.angle_deg = DATA_W'(a);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checkOutput("busy_after_start", int'(bus.busy), 1);
    n       = 0;
    ov_at   = -1;
    done_at = -1;
    while (done_at < 0 && n < 20) begin
      if (repulse && n == 2) begin
        bus.start     = 1'b1;
        bus.angle_deg = DATA_W'(other);
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
      if (bus.out_valid) ov_at = n;
      if (bus.done) done_at = n;
    end
    bus.start = 1'b0;
    checkOutput($sformatf("out_valid_edge(%0d)", a), ov_at, exp_ov);
    checkOutput($sformatf("done_edge(%0d)", a), done_at, exp_done);
    checkOutput($sformatf("reduced(%0d)", a), int'(bus.reduced_deg), exp_red);
    checkOutput($sformatf("sin_neg(%0d)", a), int'(bus.sin_neg), int'(exp_sn));
    checkOutput($sformatf("cos_neg(%0d)", a), int'(bus.cos_neg), int'(exp_cn));
    checkOutput($sformatf("error(%0d)", a), int'(bus.error), int'(exp_err));
    checkOutput($sformatf("busy_at_done(%0d)", a), int'(bus.busy), 0);
    prev_red = exp_red;
    prev_sin = exp_sn;
    prev_cos = exp_cn;
  endtask

  task automatic resetDuringWrap(input int a);
    int done_seen;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.angle_deg = DATA_W'(a);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_reduced", int'(bus.reduced_deg), 0);
    checkOutput("rst_flags", int'({bus.sin_neg, bus.cos_neg}), 0);
    checkOutput("rst_valid_done_err", int'({bus.out_valid, bus.done, bus.error}), 0);
    checkOutput("rst_busy", int'(bus.busy), 0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.out_valid) done_seen++;
    end
    checkOutput("rst_no_done", done_seen, 0);
    checkOutput("rst_idle_busy", int'(bus.busy), 0);
    prev_red = 0;
    prev_sin = 1'b0;
    prev_cos = 1'b0;
  endtask

  initial begin
    int dir_angles[] = '{45, 135, 180, 270, -999, 999, 1000, 30, -1000, 30,
                         0, 359, 90, 91, 271, -360, 360, -1};
    checks        = 0;
    errors        = 0;
    prev_red      = 0;
    prev_sin      = 1'b0;
    prev_cos      = 1'b0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.angle_deg = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_reduced", int'(bus.reduced_deg), 0);
    checkOutput("reset_ctrl", int'({bus.out_valid, bus.done, bus.error, bus.busy}), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (dir_angles[i]) applyStimulus(dir_angles[i], 1'b0, 0);

    // A start re-pulsed mid-WRAP must not disturb the running operation.
    applyStimulus(-999, 1'b1, 45);
    applyStimulus(700, 1'b1, -200);

    resetDuringWrap(999);
    applyStimulus(200, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(int'($urandom_range(2200)) - 1100, 1'b0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
